// File: rtl/beat_gen_pkg.sv
// Shared definitions for the beat generator: channel mode encodings and
// the prescaler divide-ratio helper.
package beat_gen_pkg;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_t;

   function automatic int calc_div(input int clk_freq, input int tick_freq);
      return clk_freq / tick_freq;
   endfunction

endpackage

// File: rtl/beat_gen_channel.sv
// One beat channel: phase counter, mode/burst state and registered outputs.
// A write always wins over a coincident tick.
module beat_gen_channel
   import beat_gen_pkg::*;
#(
   parameter int PERIOD_W = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                tick,
   input  logic                wr,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PERIOD_W-1:0] cfg_high,
   input  logic [7:0]          cfg_count,
   output logic                beat,
   output logic                busy,
   output logic                done
);

   mode_t               mode;
   logic [PERIOD_W-1:0] period;
   logic [PERIOD_W-1:0] high;
   logic [PERIOD_W-1:0] phase;
   logic [7:0]          remaining;

   logic                last;
   logic [PERIOD_W-1:0] next_phase;
   logic                hi_next;
   logic [PERIOD_W-1:0] p_in;

   always_comb begin
      last       = (phase == period - PERIOD_W'(1));
      next_phase = last ? '0 : phase + PERIOD_W'(1);
      hi_next    = (next_phase < high);
      p_in       = (cfg_period == '0) ? PERIOD_W'(1) : cfg_period;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mode      <= MODE_OFF;
         period    <= PERIOD_W'(1);
         high      <= '0;
         phase     <= '0;
         remaining <= '0;
         beat      <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wr) begin
            period    <= p_in;
            high      <= cfg_high;
            remaining <= cfg_count;
            phase     <= '0;
            case (mode_t'(cfg_mode))
               MODE_OFF: begin
                  mode <= MODE_OFF;
                  beat <= 1'b0;
                  busy <= 1'b0;
               end
               MODE_ON: begin
                  mode <= MODE_ON;
                  beat <= 1'b1;
                  busy <= 1'b0;
               end
               MODE_BLINK: begin
                  mode <= MODE_BLINK;
                  beat <= (cfg_high != '0);
                  busy <= 1'b0;
               end
               default: begin
                  // An empty burst completes immediately without ever going busy.
                  if (cfg_count == 8'd0) begin
                     mode <= MODE_OFF;
                     beat <= 1'b0;
                     busy <= 1'b0;
                     done <= 1'b1;
                  end else begin
                     mode <= MODE_BURST;
                     beat <= (cfg_high != '0);
                     busy <= 1'b1;
                  end
               end
            endcase
         end else if (tick) begin
            phase <= next_phase;
            case (mode)
               MODE_BLINK: beat <= hi_next;
               MODE_BURST: begin
                  if (last && remaining == 8'd1) begin
                     mode      <= MODE_OFF;
                     remaining <= 8'd0;
                     beat      <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end else begin
                     beat <= hi_next;
                     if (last) remaining <= remaining - 8'd1;
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: rtl/beat_gen.sv
// Multi-channel beat generator top: shared prescaler, write decode and one
// beat_gen_channel per channel.
module beat_gen
   import beat_gen_pkg::*;
#(
   parameter int CLK_FREQ  = 50000000,
   parameter int TICK_FREQ = 1000,
   parameter int CHANNELS  = 4,
   parameter int PERIOD_W  = 16,
   localparam int CH_W     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_wr,
   input  logic [CH_W-1:0]     cfg_ch,
   input  logic [1:0]          cfg_mode,
   input  logic [PERIOD_W-1:0] cfg_period,
   input  logic [PERIOD_W-1:0] cfg_high,
   input  logic [7:0]          cfg_count,
   output logic                tick,
   output logic [CHANNELS-1:0] beat,
   output logic [CHANNELS-1:0] busy,
   output logic [CHANNELS-1:0] done
);

   localparam int DIV   = calc_div(CLK_FREQ, TICK_FREQ);
   localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

   generate
      if (DIV < 2) begin : g_bad_div
         $error("beat_gen: CLK_FREQ/TICK_FREQ must be at least 2");
      end
      if (CHANNELS < 1 || CHANNELS > 16) begin : g_bad_ch
         $error("beat_gen: CHANNELS must be in 1..16");
      end
   endgenerate

   logic [CNT_W-1:0] pre_cnt;

   // tick is registered, so it rises the cycle after the counter sits at DIV-1.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else begin
         tick <= (pre_cnt == CNT_W'(DIV - 1));
         if (pre_cnt == CNT_W'(DIV - 1)) pre_cnt <= '0;
         else                            pre_cnt <= pre_cnt + CNT_W'(1);
      end
   end

   // cfg_wr is a bare strobe: always accepted; channel indices past the end match nothing.
   generate
      for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
         logic wr_en;
         assign wr_en = cfg_wr && (cfg_ch == CH_W'(g));

         beat_gen_channel #(
            .PERIOD_W(PERIOD_W)
         ) u_ch (
            .clk       (clk),
            .rst       (rst),
            .tick      (tick),
            .wr        (wr_en),
            .cfg_mode  (cfg_mode),
            .cfg_period(cfg_period),
            .cfg_high  (cfg_high),
            .cfg_count (cfg_count),
            .beat      (beat[g]),
            .busy      (busy[g]),
            .done      (done[g])
         );
      end
   endgenerate

endmodule

// File: tb/tb_beat_gen.sv
// Bench for beat_gen: directed scenarios then random writes/resets, every
// cycle compared against a tick-count reference model.
module tb_beat_gen;

   localparam int CLK_FREQ  = 10;
   localparam int TICK_FREQ = 1;
   localparam int DIV       = 10;
   localparam int CHANNELS  = 5;
   localparam int PERIOD_W  = 8;
   localparam int CH_W      = 3;

   logic                clk = 1'b0;
   logic                rst = 1'b1;
   logic                cfg_wr = 1'b0;
   logic [CH_W-1:0]     cfg_ch = '0;
   logic [1:0]          cfg_mode = '0;
   logic [PERIOD_W-1:0] cfg_period = '0;
   logic [PERIOD_W-1:0] cfg_high = '0;
   logic [7:0]          cfg_count = '0;
   logic                tick;
   logic [CHANNELS-1:0] beat, busy, done;

   int checks = 0;
   int errors = 0;

   beat_gen #(
      .CLK_FREQ (CLK_FREQ),
      .TICK_FREQ(TICK_FREQ),
      .CHANNELS (CHANNELS),
      .PERIOD_W (PERIOD_W)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_wr    (cfg_wr),
      .cfg_ch    (cfg_ch),
      .cfg_mode  (cfg_mode),
      .cfg_period(cfg_period),
      .cfg_high  (cfg_high),
      .cfg_count (cfg_count),
      .tick      (tick),
      .beat      (beat),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   // Reference model: a channel's output is a function of its latched config
   // and the number of ticks n seen since its last write.
   int                  m_k;
   logic                m_tick;
   int                  m_mode [CHANNELS];
   int                  m_p    [CHANNELS];
   int                  m_high [CHANNELS];
   int                  m_cnt  [CHANNELS];
   int                  m_n    [CHANNELS];
   logic [CHANNELS-1:0] m_done;

   function automatic void model_edge();
      logic t_in;
      if (rst) begin
         m_k    = 0;
         m_tick = 1'b0;
         m_done = '0;
         for (int c = 0; c < CHANNELS; c++) begin
            m_mode[c] = 0; m_p[c] = 1; m_high[c] = 0; m_cnt[c] = 0; m_n[c] = 0;
         end
      end else begin
         t_in   = m_tick;
         m_k    = m_k + 1;
         m_tick = ((m_k % DIV) == 0);
         for (int c = 0; c < CHANNELS; c++) begin
            m_done[c] = 1'b0;
            if (cfg_wr && int'(cfg_ch) == c) begin
               m_mode[c] = int'(cfg_mode);
               m_p[c]    = (cfg_period == 0) ? 1 : int'(cfg_period);
               m_high[c] = int'(cfg_high);
               m_cnt[c]  = int'(cfg_count);
               m_n[c]    = 0;
               if (m_mode[c] == 3 && m_cnt[c] == 0) begin
                  m_mode[c] = 0;
                  m_done[c] = 1'b1;
               end
            end else if (t_in && m_mode[c] >= 2) begin
               m_n[c] = m_n[c] + 1;
               if (m_mode[c] == 3 && m_n[c] == m_p[c] * m_cnt[c]) begin
                  m_mode[c] = 0;
                  m_done[c] = 1'b1;
               end
            end
         end
      end
   endfunction

   function automatic logic exp_beat(int c);
      case (m_mode[c])
         0:       return 1'b0;
         1:       return 1'b1;
         default: return ((m_n[c] % m_p[c]) < m_high[c]);
      endcase
   endfunction

   task automatic chk(input string tag, input logic [CHANNELS-1:0] got,
                      input logic [CHANNELS-1:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %b expected %b at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic run(input int n);
      logic [CHANNELS-1:0] eb, ebusy;
      repeat (n) begin
         @(posedge clk);
         model_edge();
         #1;
         for (int c = 0; c < CHANNELS; c++) begin
            eb[c]    = exp_beat(c);
            ebusy[c] = (m_mode[c] == 3);
         end
         chk("tick", CHANNELS'(tick), CHANNELS'(m_tick));
         chk("beat", beat, eb);
         chk("busy", busy, ebusy);
         chk("done", done, m_done);
      end
   endtask

   task automatic wr(input int ch, input int mode, input int period,
                     input int high, input int count);
      cfg_ch     = CH_W'(ch);
      cfg_mode   = 2'(mode);
      cfg_period = PERIOD_W'(period);
      cfg_high   = PERIOD_W'(high);
      cfg_count  = 8'(count);
      cfg_wr     = 1'b1;
      run(1);
      cfg_wr     = 1'b0;
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      run(3);
      chk("reset_beat", beat, '0);
      rst = 1'b0;
      run(5);

      // ch0 blink P=4 high=1: 10 high / 30 low
      wr(0, 2, 4, 1, 0);
      run(85);

      // ch1 burst P=2 high=1 count=3
      wr(1, 3, 2, 1, 3);
      run(75);

      // Degenerate blink configs
      wr(3, 2, 4, 0, 0);
      wr(4, 2, 4, 5, 0);
      wr(2, 2, 0, 1, 0);
      run(30);

      // Write to ch2 exactly on a tick cycle
      for (int i = 0; i < DIV + 2 && !m_tick; i++) run(1);
      checks++;
      assert (tick === 1'b1) else begin
         errors++;
         $error("FAIL tick_align: observed %b expected 1 at %0t", tick, $time);
      end
      wr(2, 2, 4, 2, 0);
      run(60);

      // Reset mid-burst: everything drops, no done
      wr(1, 3, 3, 2, 5);
      run(25);
      rst = 1'b1;
      run(1);
      chk("rst_mid_done", done, '0);
      chk("rst_mid_busy", busy, '0);
      rst = 1'b0;
      run(3);

      // Out-of-range channel is ignored
      wr(5, 1, 1, 1, 0);
      run(2);
      wr(7, 3, 2, 1, 2);
      run(5);

      // Empty burst: immediate done, never busy
      wr(1, 3, 2, 1, 0);
      chk("burst0_done", done, CHANNELS'(2));
      run(5);

      // Rewrite during a running burst
      wr(1, 3, 2, 1, 4);
      run(25);
      wr(1, 3, 3, 1, 1);
      run(40);

      // Random writes and occasional resets
      repeat (3000) begin
         cfg_wr     = ($urandom_range(0, 11) == 0);
         cfg_ch     = CH_W'($urandom_range(0, 7));
         cfg_mode   = 2'($urandom_range(0, 3));
         cfg_period = PERIOD_W'($urandom_range(0, 6));
         cfg_high   = PERIOD_W'($urandom_range(0, 7));
         cfg_count  = 8'($urandom_range(0, 4));
         rst        = ($urandom_range(0, 599) == 0);
         run(1);
      end
      cfg_wr = 1'b0;
      rst    = 1'b0;
      run(20);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
